mdu_unit: RTL
=============

# mdu_unit

Multiply/divide unit for the E stage of the five-stage pipeline. It executes mult/multu/div/divu with fixed multi-cycle latency and holds the architectural HI/LO registers. It serves mfhi/mflo reads on `mduo`, which travels down the pipeline to the writeback register. It raises `busy` so the stall unit can hold later MDU instructions in D.

## Interface

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state on the next posedge
- op_valid  in  1  E-stage instruction is an MDU op (low for bubbles)
- mdu_op  in  4  operation code (encodings in mdu_pkg)
- a  in  32  rs operand, already forwarded
- b  in  32  rt operand, already forwarded
- busy  out  1  mult/div in flight
- mduo  out  32  HI for MFHI, LO for MFLO, 0 otherwise; combinational
- hi  out  32  architectural HI
- lo  out  32  architectural LO

## Operation

Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9–15 are treated as NONE.

FSM states:
- IDLE -> RUN on accepted MULT/MULTU/DIV/DIVU.
- RUN -> IDLE when the counter reaches 1.

RUN behaviour:
- On accept, the unit computes the 64-bit result from `a`/`b` and stores it in internal hi_tmp/lo_tmp.
- The counter loads MULT_CYCLES or DIV_CYCLES.
- The counter decrements each cycle in RUN.
- On the final RUN cycle, hi <= hi_tmp, lo <= lo_tmp, and the FSM returns to IDLE.

Arithmetic:
- MULT: signed 32x32 to 64; {HI,LO} = product.
- MULTU: unsigned 32x32 to 64; {HI,LO} = product.
- DIV: LO = signed quotient truncated toward zero; HI = remainder with the dividend's sign.
- DIVU: unsigned quotient and remainder.
- DIV with a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (b=0, DIV or DIVU): the unit enters RUN for full latency but HI/LO keep their previous values.

Moves and reads:
- MTHI: hi <= a at the posedge in IDLE.
- MTLO: lo <= a at the posedge in IDLE.
- MFHI/MFLO: `mduo` reflects the current hi/lo combinationally. No state change.

Busy rule:
- While busy=1, every op_valid op is ignored and state is untouched.
- The stall unit guarantees no MDU op reaches E while busy or while a mult/div is starting.
- The bench asserts on any violation.

Reset:
- Any cycle, including mid-RUN, returns the unit to IDLE.
- hi=0, lo=0, counter=0, busy=0. Pending result discarded.

## Timing

- Reset values: busy=0, hi=0, lo=0, mduo=0 (with op_valid=0).
- Mult/div accepted at posedge P0 means op_valid, op and operands were sampled in the preceding cycle.
- busy=1 during the N cycles after P0, where N = MULT_CYCLES or DIV_CYCLES.
- busy falls and hi/lo take new values at posedge P0+N.
- An MFHI/MFLO in E in the first cycle after P0+N reads the new value.
- MTHI/MTLO take effect at the posedge that samples them. A same-cycle MFHI sees the old value; the next cycle sees the new one.
- Same-cycle MT* and mult/div start cannot occur: the single op field prevents it.
- busy is a register output with no combinational path from the inputs.
- mduo is combinational from mdu_op, op_valid, hi and lo only.

## Structure

- Shared package mdu_pkg holds:
  - op-code constants (4-bit);
  - default MULT_CYCLES/DIV_CYCLES values;
  - the state encoding (IDLE, RUN).
  The decoder, stall unit and this block all import it.
- No sub-module. Arithmetic uses native signed/unsigned multiply, divide and modulo; the counter and state live in one sequential block.

## Test plan

1. Reset, then MTHI a=0x12345678 -> next cycle MFHI gives mduo=0x12345678; lo stays 0.
2. MULT a=0xFFFFFFFE (-2), b=3 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 -> lo=3, hi=1.
4. With hi=0xAA and lo=0xBB, DIVU b=0 -> busy 10 cycles; hi=0xAA and lo=0xBB are unchanged.
5. During MULT, on the third busy cycle, apply MTLO a=0x55 and MULT a=9, b=9 -> both ignored; the original product lands; the bench assertion fires.
6. Assert reset on the fourth busy cycle of a DIV -> the next cycle shows busy=0, hi=0, lo=0; no later update occurs.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit, its decoder and the stall unit.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for the four ops that occupy the unit for multiple cycles.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit: fixed-latency mult/div, architectural HI/LO, MFHI/MFLO read port.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | accepting ops; MT* write HI/LO, mult/div starts a run
// ST_RUN  | result parked in hi_tmp/lo_tmp, counter running down to 1
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] mduo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [31:0]      hi_tmp_q, hi_tmp_d;
    logic [31:0]      lo_tmp_q, lo_tmp_d;
    logic             wr_q, wr_d;

    logic signed [63:0] a_sx, b_sx, prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] dvs_s, quo_s, rem_s;
    logic [31:0]        dvs_u, quo_u, rem_u;
    logic               b_zero, div_ovf;

    // Arithmetic results for the current operands. A zero divisor (and the
    // one signed-overflow case) is steered to a divisor of 1 so the dividers
    // never see an undefined input; the zero case is then suppressed via wr.
    always_comb begin
        a_sx    = {{32{a[31]}}, a};
        b_sx    = {{32{b[31]}}, b};
        prod_s  = a_sx * b_sx;
        prod_u  = {32'd0, a} * {32'd0, b};
        b_zero  = (b == 32'd0);
        div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        dvs_s   = (b_zero || div_ovf) ? 32'sd1 : $signed(b);
        quo_s   = $signed(a) / dvs_s;
        rem_s   = $signed(a) % dvs_s;
        dvs_u   = b_zero ? 32'd1 : b;
        quo_u   = a / dvs_u;
        rem_u   = a % dvs_u;
    end

    // Next-state: accept ops in IDLE, count down in RUN, commit on the last RUN cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        wr_d     = wr_q;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (mdu_op)
                        OP_MULT: begin
                            state_d  = ST_RUN;
                            cnt_d    = MULT_LOAD;
                            hi_tmp_d = prod_s[63:32];
                            lo_tmp_d = prod_s[31:0];
                            wr_d     = 1'b1;
                        end
                        OP_MULTU: begin
                            state_d  = ST_RUN;
                            cnt_d    = MULT_LOAD;
                            hi_tmp_d = prod_u[63:32];
                            lo_tmp_d = prod_u[31:0];
                            wr_d     = 1'b1;
                        end
                        OP_DIV: begin
                            state_d  = ST_RUN;
                            cnt_d    = DIV_LOAD;
                            hi_tmp_d = rem_s;
                            lo_tmp_d = quo_s;
                            wr_d     = !b_zero;
                        end
                        OP_DIVU: begin
                            state_d  = ST_RUN;
                            cnt_d    = DIV_LOAD;
                            hi_tmp_d = rem_u;
                            lo_tmp_d = quo_u;
                            wr_d     = !b_zero;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_LAST;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter and HI/LO registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            wr_q     <= wr_d;
        end
    end

    // Read port: combinational from the op field and the architectural registers only.
    always_comb begin
        mduo = 32'd0;
        if (op_valid && (mdu_op == OP_MFHI)) mduo = hi_q;
        if (op_valid && (mdu_op == OP_MFLO)) mduo = lo_q;
    end

    assign busy = (state_q == ST_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
